// File: rtl/carga_pkg.sv
// -----------------------------------------------------------------------------
// carga_pkg
// Shared constants for the program loader: the load command byte, the program
// terminator word, the loader FSM state encoding and the word geometry.
// -----------------------------------------------------------------------------
package carga_pkg;

    // Byte that starts a program load ('L').
    localparam logic [7:0]  CMD_LOAD  = 8'h4C;

    // Instruction word that terminates the program; it is still written.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Word geometry: LEN / NB_BYTE bytes per instruction word.
    localparam int          WORD_LEN       = 32;
    localparam int          BYTE_LEN       = 8;
    localparam int          BYTES_PER_WORD = WORD_LEN / BYTE_LEN;

    // Index of the last byte of a word in the 2-bit byte counter.
    localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

    // Loader FSM states (2-bit encoding).
    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_LOAD     = 2'd1;
    localparam logic [1:0]  ST_ACK_WAIT = 2'd2;
    localparam logic [1:0]  ST_DONE     = 2'd3;

endpackage

// File: rtl/ensamblador_palabra.sv
// -----------------------------------------------------------------------------
// ensamblador_palabra
// Assembles a stream of bytes into instruction words, MSB first.
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-low reset
//   i_clear          synchronous clear of the shift register and byte counter
//   i_enable         bytes are only accepted while high
//   i_byte_valid     one-cycle pulse, i_byte valid in that cycle
//   i_byte           incoming byte
//   o_word           last completed word (holds between completions)
//   o_word_ready     one-cycle pulse in the cycle after the last byte arrives
// -----------------------------------------------------------------------------
module ensamblador_palabra
    import carga_pkg::*;
#(
    parameter int LEN     = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic [LEN-1:0]     o_word,
    output logic               o_word_ready
);

    logic [LEN-1:0] shift_q;
    logic [1:0]     byte_cnt_q;
    logic [LEN-1:0] shift_next;

    assign shift_next = {shift_q[LEN-NB_BYTE-1:0], i_byte};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shift_q      <= '0;
            byte_cnt_q   <= 2'd0;
            o_word       <= '0;
            o_word_ready <= 1'b0;
        end else begin
            o_word_ready <= 1'b0;
            if (i_clear) begin
                shift_q    <= '0;
                byte_cnt_q <= 2'd0;
            end else if (i_enable && i_byte_valid) begin
                shift_q    <= shift_next;
                byte_cnt_q <= byte_cnt_q + 2'd1;   // wraps 3 -> 0
                if (byte_cnt_q == LAST_BYTE_IDX) begin
                    // Latch the full word separately so the write data stays
                    // stable while the next word is being shifted in.
                    o_word       <= shift_next;
                    o_word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/unidad_carga_programa.sv
// -----------------------------------------------------------------------------
// unidad_carga_programa
// Program loader: receives a byte stream from the UART, packs it into 32-bit
// instruction words, writes them sequentially into instruction memory, keeps
// the CPU disabled until the HALT word (or memory full), acknowledges with the
// written word count over the UART and then enables the CPU.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_rx_data, i_rx_done    received byte and its one-cycle valid pulse
//   i_tx_done               transmitter finished sending the acknowledge
//   o_tx_data, o_tx_start   acknowledge byte (word count) and one-cycle request
//   o_wr_en/addr/data       instruction memory write port, one cycle per word
//   o_cpu_enable            pipeline enable, high only in DONE
//   o_error                 memory filled before HALT; sticky until next load
//   o_state                 current FSM state (debug visibility)
//
// Handshake: i_rx_done and i_tx_done are single-cycle strobes with no
// backpressure; o_tx_start is a single-cycle request, and only an i_tx_done
// seen after the o_tx_start cycle completes the acknowledge.
// -----------------------------------------------------------------------------
module unidad_carga_programa
    import carga_pkg::*;
#(
    parameter int LEN           = 32,
    parameter int NB_ADDRESS_IM = 8,
    parameter int NB_BYTE       = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NB_BYTE-1:0]       i_rx_data,
    input  logic                     i_rx_done,
    input  logic                     i_tx_done,
    output logic [NB_BYTE-1:0]       o_tx_data,
    output logic                     o_tx_start,
    output logic                     o_wr_en,
    output logic [NB_ADDRESS_IM-1:0] o_wr_addr,
    output logic [LEN-1:0]           o_wr_data,
    output logic                     o_cpu_enable,
    output logic                     o_error,
    output logic [1:0]               o_state
);

    localparam logic [NB_ADDRESS_IM-1:0] ADDR_MAX = {NB_ADDRESS_IM{1'b1}};

    logic [1:0]               state_q;
    logic [NB_ADDRESS_IM:0]   word_cnt_q;   // one extra bit: a full memory is representable
    logic [NB_ADDRESS_IM:0]   word_cnt_next;
    logic                     load_cmd;
    logic                     start_load;
    logic                     word_ready;
    logic [LEN-1:0]           word;

    assign load_cmd      = i_rx_done && (i_rx_data == CMD_LOAD);
    // CMD_LOAD only acts as a command outside LOAD/ACK_WAIT; inside LOAD it is data.
    assign start_load    = load_cmd && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign word_cnt_next = word_cnt_q + 1'b1;

    ensamblador_palabra #(
        .LEN     (LEN),
        .NB_BYTE (NB_BYTE)
    ) u_ensamblador (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (start_load),
        .i_enable     (state_q == ST_LOAD),
        .i_byte_valid (i_rx_done),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_ready (word_ready)
    );

    // The write strobe is the assembler's registered completion pulse, so the
    // memory write lands one cycle after the 4th byte's i_rx_done.
    assign o_wr_en   = word_ready;
    assign o_wr_data = word;
    assign o_state   = state_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            o_wr_addr    <= '0;
            word_cnt_q   <= '0;
            o_tx_start   <= 1'b0;
            o_tx_data    <= '0;
            o_cpu_enable <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_load) begin
                        state_q    <= ST_LOAD;
                        o_wr_addr  <= '0;
                        word_cnt_q <= '0;
                        o_error    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Decisions are taken in the strobe cycle, against the
                    // address being written right now.
                    if (word_ready) begin
                        word_cnt_q <= word_cnt_next;
                        if (word == HALT_WORD) begin
                            state_q    <= ST_ACK_WAIT;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= NB_BYTE'(word_cnt_next);
                        end else if (o_wr_addr == ADDR_MAX) begin
                            state_q    <= ST_ACK_WAIT;
                            o_error    <= 1'b1;
                            o_tx_start <= 1'b1;
                            o_tx_data  <= NB_BYTE'(word_cnt_next);
                        end else begin
                            o_wr_addr <= o_wr_addr + 1'b1;
                        end
                    end
                end
                ST_ACK_WAIT: begin
                    // A tx_done in the same cycle as tx_start cannot belong to
                    // this acknowledge, so it is ignored.
                    if (i_tx_done && !o_tx_start) begin
                        state_q      <= ST_DONE;
                        o_cpu_enable <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start_load) begin
                        state_q      <= ST_LOAD;
                        o_cpu_enable <= 1'b0;
                        o_wr_addr    <= '0;
                        word_cnt_q   <= '0;
                        o_error      <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_carga_programa.sv
// -----------------------------------------------------------------------------
// tb_unidad_carga_programa
// Directed bench for the program loader, built with a 4-word instruction
// memory (NB_ADDRESS_IM = 2) so the overflow path is reachable.
// -----------------------------------------------------------------------------
module tb_unidad_carga_programa;
    import carga_pkg::*;

    localparam int NB_ADDR = 2;

    logic               clk;
    logic               rst_n;
    logic [7:0]         rx_data;
    logic               rx_done;
    logic               tx_done;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               wr_en;
    logic [NB_ADDR-1:0] wr_addr;
    logic [31:0]        wr_data;
    logic               cpu_enable;
    logic               error;
    logic [1:0]         state;

    int total_checks = 0;
    int fail_checks  = 0;
    int wr_seen      = 0;

    // Expected writes: {addr, data}.
    logic [NB_ADDR+31:0] exp_q[$];

    unidad_carga_programa #(
        .LEN           (32),
        .NB_ADDRESS_IM (NB_ADDR),
        .NB_BYTE       (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cpu_enable (cpu_enable),
        .o_error      (error),
        .o_state      (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) else begin
            fail_checks++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard (write monitor) ----------------
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_seen++;
            check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0)
                check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the next negedge, where outputs reflect
    // the edge that captured the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Called in the strobe cycle of the terminating write.
    task automatic finish_ack(input logic [7:0] exp_cnt);
        @(negedge clk);
        check("ack_tx_start", 64'(tx_start), 64'd1);
        check("ack_tx_data", 64'(tx_data), 64'(exp_cnt));
        check("ack_state", 64'(state), 64'(ST_ACK_WAIT));
        tx_done = 1'b1;                       // same cycle as tx_start: ignored
        @(negedge clk);
        tx_done = 1'b0;
        check("ack_ignored_state", 64'(state), 64'(ST_ACK_WAIT));
        check("ack_start_one_cycle", 64'(tx_start), 64'd0);
        check("ack_cpu_still_off", 64'(cpu_enable), 64'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("ack_cpu_on", 64'(cpu_enable), 64'd1);
        check("ack_state_done", 64'(state), 64'(ST_DONE));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 64'(state), 64'(ST_IDLE));
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_tx_start"}, 64'(tx_start), 64'd0);
        check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        check({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int seen_before;
        rst_n   = 1'b0;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Idle filtering: non-command bytes do nothing.
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hFF);
        @(negedge clk);
        check("idle_state", 64'(state), 64'(ST_IDLE));
        check("idle_cpu", 64'(cpu_enable), 64'd0);
        check("idle_no_write", 64'(wr_seen), 64'd0);

        // Load one instruction plus HALT.
        send_byte(CMD_LOAD);
        check("load_state", 64'(state), 64'(ST_LOAD));
        exp_q.push_back({2'd0, 32'h2008_0005});
        exp_q.push_back({2'd1, 32'hFFFF_FFFF});
        send_word(32'h2008_0005);
        check("l1_wr_en", 64'(wr_en), 64'd1);
        check("l1_wr_addr", 64'(wr_addr), 64'd0);
        check("l1_wr_data", 64'(wr_data), 64'h2008_0005);
        @(negedge clk);
        check("l1_wr_en_pulse", 64'(wr_en), 64'd0);
        check("l1_addr_inc", 64'(wr_addr), 64'd1);
        send_word(32'hFFFF_FFFF);
        check("l1_halt_wr_en", 64'(wr_en), 64'd1);
        check("l1_halt_addr", 64'(wr_addr), 64'd1);
        finish_ack(8'h02);
        check("l1_error", 64'(error), 64'd0);

        // Overflow: four non-HALT words fill the 4-word memory.
        send_byte(CMD_LOAD);
        check("ovf_cpu_off", 64'(cpu_enable), 64'd0);
        exp_q.push_back({2'd0, 32'h1111_1111});
        exp_q.push_back({2'd1, 32'h2222_2222});
        exp_q.push_back({2'd2, 32'h3333_3333});
        exp_q.push_back({2'd3, 32'h4444_4444});
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        check("ovf_last_addr", 64'(wr_addr), 64'd3);
        finish_ack(8'h04);
        check("ovf_error", 64'(error), 64'd1);
        seen_before = wr_seen;
        send_word(32'hAAAA_AAAA);
        @(negedge clk);
        check("ovf_no_more_writes", 64'(wr_seen), 64'(seen_before));
        check("ovf_error_sticky", 64'(error), 64'd1);
        check("ovf_state_done", 64'(state), 64'(ST_DONE));

        // Reload from DONE.
        send_byte(CMD_LOAD);
        check("rl_cpu_off", 64'(cpu_enable), 64'd0);
        check("rl_error_clr", 64'(error), 64'd0);
        check("rl_addr_clr", 64'(wr_addr), 64'd0);
        check("rl_state", 64'(state), 64'(ST_LOAD));
        exp_q.push_back({2'd0, 32'h0000_0000});
        exp_q.push_back({2'd1, 32'hFFFF_FFFF});
        send_word(32'h0000_0000);
        check("rl_wr_addr0", 64'(wr_addr), 64'd0);
        send_word(32'hFFFF_FFFF);
        finish_ack(8'h02);

        // Command byte value used as data inside LOAD.
        send_byte(CMD_LOAD);
        exp_q.push_back({2'd0, 32'h4C4C_4C4C});
        exp_q.push_back({2'd1, 32'hFFFF_FFFF});
        send_word(32'h4C4C_4C4C);
        check("cmd_data_wr_en", 64'(wr_en), 64'd1);
        check("cmd_data_word", 64'(wr_data), 64'h4C4C_4C4C);
        check("cmd_data_state", 64'(state), 64'(ST_LOAD));
        @(negedge clk);
        check("cmd_data_addr", 64'(wr_addr), 64'd1);
        send_word(32'hFFFF_FFFF);
        finish_ack(8'h02);

        // Reset in the middle of a load, after 6 data bytes.
        send_byte(CMD_LOAD);
        exp_q.push_back({2'd0, 32'hDEAD_BEEF});
        send_word(32'hDEAD_BEEF);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        check("mid_addr_before", 64'(wr_addr), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(CMD_LOAD);
        exp_q.push_back({2'd0, 32'h0102_0304});
        exp_q.push_back({2'd1, 32'hFFFF_FFFF});
        send_word(32'h0102_0304);
        check("post_rst_addr", 64'(wr_addr), 64'd0);
        check("post_rst_data", 64'(wr_data), 64'h0102_0304);
        send_word(32'hFFFF_FFFF);
        finish_ack(8'h02);

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/unidad_carga_programa.md
# unidad_carga_programa

Program loader that fills the instruction memory read by instruction fetch. It receives a byte stream from the UART receiver, assembles the bytes into 32-bit instruction words, and writes them sequentially into instruction memory. It holds the MIPS pipeline disabled until the program terminator arrives, then acknowledges the load over the UART transmitter and releases the CPU.

## Interface
Parameters:
- LEN, 32, instruction word width; fixed at 4 bytes.
- NB_ADDRESS_IM, 8, instruction memory word-address width (depth = 2^NB_ADDRESS_IM words).
- NB_BYTE, 8, UART data width.

Ports:
- i_clk  input  1  system clock; single clock domain, rising edge.
- i_rst  input  1  reset, asynchronous, active-low.
- i_rx_data  input  NB_BYTE  byte from the UART receiver.
- i_rx_done  input  1  one-cycle pulse; i_rx_data is valid in that cycle.
- i_tx_done  input  1  one-cycle pulse from the UART transmitter when the byte has been sent.
- o_tx_data  output  NB_BYTE  acknowledge byte.
- o_tx_start  output  1  one-cycle request to transmit o_tx_data.
- o_wr_en  output  1  instruction memory write strobe, one cycle per word.
- o_wr_addr  output  NB_ADDRESS_IM  instruction memory word address.
- o_wr_data  output  LEN  instruction word.
- o_cpu_enable  output  1  enables the pipeline (PC update plus all latches).
- o_error  output  1  memory overflowed before the terminator arrived; sticky until the next load.

## Operation
- Constants:
  - CMD_LOAD = 8'h4C ('L').
  - HALT_WORD = 32'hFFFF_FFFF.
- States: IDLE, LOAD, ACK_WAIT, DONE.
- IDLE:
  - o_cpu_enable=0.
  - A byte equal to CMD_LOAD moves to LOAD and clears the word address, byte counter, word count and o_error.
  - Any other byte is ignored.
- LOAD:
  - Each i_rx_done shifts the byte into the assembler MSB-first: word = {word[23:0], byte}.
  - The 2-bit byte counter increments and wraps from 3 to 0.
  - On the 4th byte the completed word is written at the current address.
  - If the word is HALT_WORD, the write is still performed, then the block goes to ACK_WAIT.
  - Otherwise, if the address is 2^NB_ADDRESS_IM-1 (memory full), it sets o_error and goes to ACK_WAIT.
  - Otherwise the address increments.
  - CMD_LOAD bytes inside LOAD are data, not commands.
- ACK_WAIT:
  - o_tx_data = number of words written, including HALT, as [7:0] (mod 256).
  - o_tx_start pulses in the first cycle of this state.
  - The block waits for i_tx_done and then goes to DONE.
  - rx bytes in this state are ignored.
- DONE:
  - o_cpu_enable=1.
  - A CMD_LOAD byte returns to LOAD: o_cpu_enable drops in the same cycle, and address, counter and o_error are cleared.
  - Other bytes are ignored.
- Word count is NB_ADDRESS_IM+1 bits wide internally, so a full memory (2^NB_ADDRESS_IM) is representable.

## Timing
- Reset values: state=IDLE, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_tx_start=0, o_tx_data=0, o_cpu_enable=0, o_error=0, assembler and counters=0.
- All outputs are registered.
- o_wr_en, o_wr_addr and o_wr_data are asserted in the cycle after the i_rx_done of the 4th byte (latency 1), for exactly one cycle.
- The address increment becomes visible on the cycle after the write strobe.
- o_tx_start is high for exactly one cycle, in the cycle after the transition into ACK_WAIT.
- If i_tx_done arrives in that same cycle, it is ignored; only i_tx_done pulses from the following cycle onward count.
- o_cpu_enable rises in the cycle after the i_tx_done that is accepted.
- i_rx_done coinciding with a write strobe is captured normally, because the assembler is independent of the strobe.
- Reset asserted mid-load forces every output to its reset value immediately (asynchronously). Memory contents already written are not cleared.

## Structure
- Package carga_pkg holds:
  - CMD_LOAD and HALT_WORD;
  - the state enum/localparams (2-bit encoding);
  - the word width in bytes (LEN/NB_BYTE).
- Sub-module ensamblador_palabra contains the shift register, byte counter and word_ready pulse. The top module contains the FSM, address and word counters, and the tx handshake.

## Test plan
- Load one instruction. Send 4C, 20 08 00 05, FF FF FF FF.
  - Required: o_wr_en at addr 0 with 32'h2008_0005, then at addr 1 with 32'hFFFF_FFFF.
  - Required: o_tx_start with o_tx_data=8'h02.
  - Required: o_cpu_enable=1 the cycle after i_tx_done.
- Idle filtering. Send 00 13 FF before 4C.
  - Required: no write, state stays IDLE, o_cpu_enable=0.
- Overflow. With NB_ADDRESS_IM=2, send 4C followed by 4 non-HALT words.
  - Required: writes at addr 0..3, then o_error=1 and o_tx_data=8'h04.
  - Required: no further writes for additional bytes.
- Reload. From DONE, send 4C, then 00 00 00 00, FF FF FF FF.
  - Required: o_cpu_enable falls in the cycle after the 4C i_rx_done, o_error clears, and writes restart at addr 0.
- Reset mid-load. Assert i_rst after 6 data bytes.
  - Required: outputs return to their reset values immediately.
  - Required: after release, a new 4C load starts at addr 0 with the byte counter at 0.
- Data equal to the command. In LOAD, send 4C 4C 4C 4C.
  - Required: the word 32'h4C4C_4C4C is written; no restart occurs.
